// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm-clock key entry path.
// The package holds the key codes, the digit range and the entry FSM states.
package alarm_pkg;

    localparam logic [3:0] NOKEY     = 4'hA;
    localparam logic [3:0] DIGIT_MAX = 4'd9;

    typedef enum logic [2:0] {
        SHOW_TIME,
        KEY_STORED,
        KEY_WAITED,
        KEY_ENTRY,
        SHOW_ALARM,
        SET_ALARM,
        SET_TIME
    } state_t;

    function automatic logic is_digit(input logic [3:0] code);
        return code <= DIGIT_MAX;
    endfunction

    // Codes above 9 that are not the no-key code are folded into it.
    function automatic logic [3:0] map_key(input logic [3:0] code, input logic [3:0] nokey);
        return (is_digit(code) || code == nokey) ? code : nokey;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Keypad debouncer: a code must hold for DEBOUNCE_CYC identical samples before
// it reaches key_out; new_digit flags a stable NOKEY-to-digit transition.
module key_debounce #(
    parameter int         DEBOUNCE_CYC = 4,
    parameter logic [3:0] NOKEY        = 4'hA
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] key,
    output logic [3:0] key_out,
    output logic       new_digit
);
    import alarm_pkg::*;

    localparam int CW = $clog2(DEBOUNCE_CYC + 1);

    logic [3:0]    mapped;
    logic [3:0]    sample;
    logic [CW-1:0] count;
    logic          stable_now;

    assign mapped = map_key(key, NOKEY);

    // Fires once per stable run: on the sample that completes the required run.
    assign stable_now = (mapped == sample) && (count == CW'(DEBOUNCE_CYC - 1));

    // NOTE: state updates use non-blocking assignments so every register samples
    // the pre-edge values; blocking here would chain sample -> count in one edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sample    <= NOKEY;
            count     <= '0;
            key_out   <= NOKEY;
            new_digit <= 1'b0;
        end else begin
            new_digit <= 1'b0;
            sample    <= mapped;
            if (mapped != sample)
                count <= '0;
            else if (count != CW'(DEBOUNCE_CYC))
                count <= count + 1'b1;
            if (stable_now) begin
                key_out   <= sample;
                new_digit <= (key_out == NOKEY) && is_digit(sample);
            end
        end
    end

endmodule

// File: rtl/key_entry_fsm.sv
// Key entry sequencer: debounced digit capture, commit to alarm or time,
// and abandonment of an idle entry session after TIMEOUT_S seconds.
module key_entry_fsm #(
    parameter int         DEBOUNCE_CYC = 4,
    parameter int         TIMEOUT_S    = 10,
    parameter logic [3:0] NOKEY        = 4'hA
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       one_second,
    input  logic [3:0] key,
    input  logic       alarm_button,
    input  logic       time_button,
    output logic [3:0] key_out,
    output logic       shift,
    output logic       show_new_time,
    output logic       show_alarm,
    output logic       load_new_alarm,
    output logic       load_new_time
);
    import alarm_pkg::*;

    localparam int TW = $clog2(TIMEOUT_S + 1);

    state_t        state;
    state_t        state_next;
    logic [TW-1:0] idle_count;
    logic          timeout;
    logic          new_digit;
    logic          key_released;
    logic          in_session;

    key_debounce #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC),
        .NOKEY       (NOKEY)
    ) u_debounce (
        .clock    (clock),
        .reset    (reset),
        .key      (key),
        .key_out  (key_out),
        .new_digit(new_digit)
    );

    assign key_released = (key_out == NOKEY);
    assign timeout      = (idle_count == TW'(TIMEOUT_S));
    assign in_session   = (state == KEY_WAITED) || (state == KEY_ENTRY);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= SHOW_TIME;
            idle_count <= '0;
        end else begin
            state <= state_next;
            if (!in_session)
                idle_count <= '0;
            else if (one_second && !timeout)
                idle_count <= idle_count + 1'b1;
        end
    end

    // NOTE: state_next gets its default before the case so every path assigns it
    // and no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            SHOW_TIME: begin
                if (alarm_button)   state_next = SHOW_ALARM;
                else if (new_digit) state_next = KEY_STORED;
            end
            KEY_STORED: state_next = KEY_WAITED;
            KEY_WAITED: begin
                if (timeout)           state_next = SHOW_TIME;
                else if (key_released) state_next = KEY_ENTRY;
            end
            KEY_ENTRY: begin
                // Buttons outrank a digit arriving in the same cycle.
                if (alarm_button)      state_next = SET_ALARM;
                else if (time_button)  state_next = SET_TIME;
                else if (new_digit)    state_next = KEY_STORED;
                else if (timeout)      state_next = SHOW_TIME;
            end
            SHOW_ALARM: begin
                if (!alarm_button) state_next = SHOW_TIME;
            end
            SET_ALARM: state_next = SHOW_TIME;
            SET_TIME:  state_next = SHOW_TIME;
            default:   state_next = SHOW_TIME;
        endcase
    end

    assign shift          = (state == KEY_STORED);
    assign show_new_time  = (state == KEY_STORED) || in_session;
    assign show_alarm     = (state == SHOW_ALARM);
    assign load_new_alarm = (state == SET_ALARM);
    assign load_new_time  = (state == SET_TIME);

endmodule

// File: tb/tb_key_entry_fsm.sv
// Directed bench for key_entry_fsm: a queue of expected digits is matched
// against every shift pulse, and session outputs are checked at each step.
module tb_key_entry_fsm;

    localparam logic [3:0] NK = 4'hA;

    logic       clock;
    logic       reset;
    logic       one_second;
    logic [3:0] key;
    logic       alarm_button;
    logic       time_button;
    logic [3:0] key_out;
    logic       shift;
    logic       show_new_time;
    logic       show_alarm;
    logic       load_new_alarm;
    logic       load_new_time;

    int vectors     = 0;
    int miscompares = 0;
    int shift_count = 0;
    int alarm_pulses = 0;
    int time_pulses  = 0;
    logic [3:0] exp_q[$];

    key_entry_fsm #(
        .DEBOUNCE_CYC(4),
        .TIMEOUT_S   (10),
        .NOKEY       (4'hA)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .one_second    (one_second),
        .key           (key),
        .alarm_button  (alarm_button),
        .time_button   (time_button),
        .key_out       (key_out),
        .shift         (shift),
        .show_new_time (show_new_time),
        .show_alarm    (show_alarm),
        .load_new_alarm(load_new_alarm),
        .load_new_time (load_new_time)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Scoreboard consumer: every shift pulse must match the oldest expected digit.
    always @(negedge clock) begin
        if (reset === 1'b0) begin
            if (shift === 1'b1) begin
                shift_count++;
                if (exp_q.size() == 0)
                    check("shift_unexpected", 8'd1, 8'd0);
                else
                    check("shift_key", {4'h0, key_out}, {4'h0, exp_q.pop_front()});
            end
            if (load_new_alarm === 1'b1) alarm_pulses++;
            if (load_new_time === 1'b1)  time_pulses++;
        end
    end

    task automatic press(input logic [3:0] d, input bit expect_shift);
        key = d;
        if (expect_shift) exp_q.push_back(d);
        repeat (8) tick();
        key = NK;
        repeat (8) tick();
    endtask

    task automatic second_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            one_second = 1'b1;
            tick();
            one_second = 1'b0;
            tick();
        end
    endtask

    function automatic logic [7:0] outs();
        return {3'b000, shift, show_new_time, show_alarm, load_new_alarm, load_new_time};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base_shift;
        int base_alarm;
        int base_time;
        bit snt_low;

        reset = 1'b1; one_second = 1'b0; key = NK;
        alarm_button = 1'b0; time_button = 1'b0;
        #2;
        check("reset_outs", outs(), 8'h00);
        check("reset_key_out", {4'h0, key_out}, 8'h0A);
        tick(); tick();
        reset = 1'b0;
        tick();
        check("idle_outs", outs(), 8'h00);

        // Reset asserted mid-session.
        press(4'd1, 1'b1);
        check("entry_show_new_time", {7'd0, show_new_time}, 8'd1);
        #2 reset = 1'b1;
        #1;
        check("midreset_outs", outs(), 8'h00);
        check("midreset_key_out", {4'h0, key_out}, 8'h0A);
        tick();
        reset = 1'b0;
        key = 4'd3;
        exp_q.push_back(4'd3);
        repeat (5) tick();
        check("lat_before", {7'd0, shift}, 8'd0);
        tick();
        check("lat_shift", {7'd0, shift}, 8'd1);
        check("lat_key_out", {4'h0, key_out}, 8'h03);
        tick();
        check("lat_one_cycle", {7'd0, shift}, 8'd0);
        key = NK;
        repeat (8) tick();

        // Inactivity timeout: 9 pulses keep the session, the 10th abandons it.
        base_alarm = alarm_pulses; base_time = time_pulses;
        second_pulses(9);
        check("to9_session", {7'd0, show_new_time}, 8'd1);
        second_pulses(1);
        check("to10_show_time", outs(), 8'h00);
        check("to_no_alarm_load", 8'(alarm_pulses - base_alarm), 8'd0);
        check("to_no_time_load", 8'(time_pulses - base_time), 8'd0);

        // Held key 5, release, then 7: two pulses, display held on the buffer.
        base_shift = shift_count;
        snt_low = 1'b0;
        key = 4'd5;
        exp_q.push_back(4'd5);
        for (int i = 0; i < 50; i++) begin
            tick();
            if (i >= 10 && !show_new_time) snt_low = 1'b1;
        end
        check("hold_one_shift", 8'(shift_count - base_shift), 8'd1);
        key = NK;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!show_new_time) snt_low = 1'b1;
        end
        key = 4'd7;
        exp_q.push_back(4'd7);
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!show_new_time) snt_low = 1'b1;
        end
        key = NK;
        repeat (8) tick();
        check("hold_two_shifts", 8'(shift_count - base_shift), 8'd2);
        check("hold_snt_steady", {7'd0, snt_low}, 8'd0);

        // Bouncing key: a single pulse once it settles.
        base_shift = shift_count;
        key = 4'd2; tick();
        key = NK;   tick();
        key = 4'd2; tick();
        key = NK;   tick();
        key = 4'd2;
        exp_q.push_back(4'd2);
        repeat (10) tick();
        key = NK;
        repeat (8) tick();
        check("bounce_one_shift", 8'(shift_count - base_shift), 8'd1);

        // Four digits then commit to the alarm.
        press(4'd1, 1'b1);
        press(4'd2, 1'b1);
        press(4'd3, 1'b1);
        press(4'd4, 1'b1);
        alarm_button = 1'b1;
        tick();
        check("set_alarm_outs", outs(), 8'h02);
        alarm_button = 1'b0;
        tick();
        check("after_alarm_outs", outs(), 8'h00);

        // Both buttons together in entry: alarm wins.
        press(4'd8, 1'b1);
        base_time = time_pulses;
        alarm_button = 1'b1; time_button = 1'b1;
        tick();
        check("both_alarm", {7'd0, load_new_alarm}, 8'd1);
        check("both_no_time", {7'd0, load_new_time}, 8'd0);
        tick();
        check("both_back_idle", outs(), 8'h00);
        tick();
        check("show_alarm_held", outs(), 8'h04);

        // A digit while the alarm is displayed is dropped.
        base_shift = shift_count;
        press(4'd9, 1'b0);
        check("alarm_view_no_shift", 8'(shift_count - base_shift), 8'd0);
        check("alarm_view_stays", {7'd0, show_alarm}, 8'd1);
        alarm_button = 1'b0; time_button = 1'b0;
        tick();
        check("alarm_view_exit", outs(), 8'h00);
        check("both_time_pulses", 8'(time_pulses - base_time), 8'd0);

        // A digit at 9 seconds clears the idle count; then commit to time.
        press(4'd6, 1'b1);
        second_pulses(9);
        press(4'd1, 1'b1);
        second_pulses(9);
        check("to_cleared_session", {7'd0, show_new_time}, 8'd1);
        time_button = 1'b1;
        tick();
        check("set_time_outs", outs(), 8'h01);
        time_button = 1'b0;
        tick();
        check("after_time_outs", outs(), 8'h00);

        check("total_alarm_pulses", 8'(alarm_pulses), 8'd2);
        check("total_time_pulses", 8'(time_pulses), 8'd1);
        check("scoreboard_drained", 8'(exp_q.size()), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
